// File: rtl/cpu_decode.sv
// RV32 instruction decode stage: registers one decoded bundle per new fetch tag.
// Define CPU_DECODE_RV32M_EN to decode the M-extension (funct7 0000001) as MULDIV.
module cpu_decode #(
  parameter int TAG_WIDTH = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_stall,
  input  logic                 i_flush,
  output logic                 o_busy,
  input  logic [TAG_WIDTH-1:0] i_tag,
  input  logic [31:0]          i_instruction,
  input  logic [31:0]          i_pc,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic [31:0]          o_pc,
  output logic [31:0]          o_instruction,
  output logic [4:0]           o_rs1,
  output logic [4:0]           o_rs2,
  output logic [4:0]           o_rd,
  output logic [31:0]          o_imm,
  output logic [2:0]           o_funct3,
  output logic                 o_funct7_5,
  output logic [3:0]           o_class,
  output logic                 o_writes_rd,
  output logic                 o_control_flow,
  output logic [31:0]          o_decoded_count
);

  typedef enum logic [3:0] {
    C_ALU = 4'd0, C_ALU_IMM = 4'd1, C_LOAD = 4'd2, C_STORE = 4'd3,
    C_BRANCH = 4'd4, C_JAL = 4'd5, C_JALR = 4'd6, C_LUI = 4'd7,
    C_AUIPC = 4'd8, C_SYSTEM = 4'd9, C_FENCE = 4'd10, C_MULDIV = 4'd11,
    C_ILLEGAL = 4'd15
  } iclass_e;

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction
  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction
  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction
  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  logic [TAG_WIDTH-1:0] last_tag_q, last_tag_d, tag_q, tag_d;
  logic [31:0]          pc_q, pc_d, instr_q, instr_d, imm_q, imm_d, count_q, count_d;
  logic [4:0]           rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [2:0]           funct3_q, funct3_d;
  logic                 f75_q, f75_d, wr_q, wr_d, cf_q, cf_d;
  iclass_e              class_q, class_d;

  iclass_e     dec_class;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_imm;
  logic        dec_wr, dec_cf, accept;

  logic [31:0] ins;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  assign ins    = i_instruction;
  assign funct7 = ins[31:25];
  assign funct3 = ins[14:12];

  always_comb begin
    dec_class = C_ILLEGAL;
    dec_rs1   = '0;
    dec_rs2   = '0;
    dec_rd    = '0;
    dec_imm   = '0;
    dec_cf    = 1'b0;
    case (ins[6:0])
      7'b0110011: begin
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
          dec_class = C_ALU;
`ifdef CPU_DECODE_RV32M_EN
        else if (funct7 == 7'b0000001)
          dec_class = C_MULDIV;
`endif
        if (dec_class != C_ILLEGAL) begin
          dec_rd = ins[11:7]; dec_rs1 = ins[19:15]; dec_rs2 = ins[24:20];
        end
      end
      7'b0010011: begin dec_class = C_ALU_IMM; dec_rd = ins[11:7]; dec_rs1 = ins[19:15]; dec_imm = imm_i(ins); end
      7'b0000011: begin dec_class = C_LOAD;    dec_rd = ins[11:7]; dec_rs1 = ins[19:15]; dec_imm = imm_i(ins); end
      7'b0100011: begin dec_class = C_STORE;   dec_rs1 = ins[19:15]; dec_rs2 = ins[24:20]; dec_imm = imm_s(ins); end
      7'b1100011: begin
        dec_class = C_BRANCH; dec_rs1 = ins[19:15]; dec_rs2 = ins[24:20];
        dec_imm = imm_b(ins); dec_cf = 1'b1;
      end
      7'b1101111: begin dec_class = C_JAL;  dec_rd = ins[11:7]; dec_imm = imm_j(ins); dec_cf = 1'b1; end
      7'b1100111: begin
        dec_class = C_JALR; dec_rd = ins[11:7]; dec_rs1 = ins[19:15];
        dec_imm = imm_i(ins); dec_cf = 1'b1;
      end
      7'b0110111: begin dec_class = C_LUI;   dec_rd = ins[11:7]; dec_imm = imm_u(ins); end
      7'b0010111: begin dec_class = C_AUIPC; dec_rd = ins[11:7]; dec_imm = imm_u(ins); end
      7'b0001111: dec_class = C_FENCE;
      7'b1110011: begin
        // funct3 0 is only legal for the four exact privileged encodings
        if (funct3 == 3'b000) begin
          if (ins == 32'h0000_0073 || ins == 32'h0010_0073) dec_class = C_SYSTEM;
          if (ins == 32'h3020_0073 || ins == 32'h1050_0073) begin
            dec_class = C_SYSTEM; dec_cf = 1'b1;
          end
        end else if (funct3 != 3'b100) begin
          dec_class = C_SYSTEM; dec_rd = ins[11:7]; dec_rs1 = ins[19:15]; dec_imm = imm_i(ins);
        end
      end
      default: dec_class = C_ILLEGAL;
    endcase
    dec_wr = (dec_rd != 5'd0);
  end

  assign accept = (i_tag != last_tag_q) && !i_stall && !i_flush;

  always_comb begin
    last_tag_d = (i_flush || accept) ? i_tag : last_tag_q;
    tag_d      = accept ? tag_q + 1'b1 : tag_q;
    count_d    = accept ? count_q + 32'd1 : count_q;
    pc_d       = accept ? i_pc : pc_q;
    instr_d    = accept ? ins : instr_q;
    rs1_d      = accept ? dec_rs1 : rs1_q;
    rs2_d      = accept ? dec_rs2 : rs2_q;
    rd_d       = accept ? dec_rd : rd_q;
    imm_d      = accept ? dec_imm : imm_q;
    funct3_d   = accept ? funct3 : funct3_q;
    f75_d      = accept ? ins[30] : f75_q;
    class_d    = accept ? dec_class : class_q;
    wr_d       = accept ? dec_wr : wr_q;
    cf_d       = accept ? dec_cf : cf_q;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      last_tag_q <= '0; tag_q <= '0; count_q <= '0; pc_q <= '0; instr_q <= '0;
      rs1_q <= '0; rs2_q <= '0; rd_q <= '0; imm_q <= '0; funct3_q <= '0;
      f75_q <= 1'b0; class_q <= C_ALU; wr_q <= 1'b0; cf_q <= 1'b0;
    end else begin
      last_tag_q <= last_tag_d; tag_q <= tag_d; count_q <= count_d; pc_q <= pc_d;
      instr_q <= instr_d; rs1_q <= rs1_d; rs2_q <= rs2_d; rd_q <= rd_d; imm_q <= imm_d;
      funct3_q <= funct3_d; f75_q <= f75_d; class_q <= class_d; wr_q <= wr_d; cf_q <= cf_d;
    end
  end

  assign o_busy          = i_stall;
  assign o_tag           = tag_q;
  assign o_pc            = pc_q;
  assign o_instruction   = instr_q;
  assign o_rs1           = rs1_q;
  assign o_rs2           = rs2_q;
  assign o_rd            = rd_q;
  assign o_imm           = imm_q;
  assign o_funct3        = funct3_q;
  assign o_funct7_5      = f75_q;
  assign o_class         = class_q;
  assign o_writes_rd     = wr_q;
  assign o_control_flow  = cf_q;
  assign o_decoded_count = count_q;

endmodule

// File: tb/tb_cpu_decode.sv
// Directed self-checking bench for cpu_decode.
module tb_cpu_decode;
  logic        clk = 1'b0;
  logic        rst, stall, flush, busy;
  logic [7:0]  tag, o_tag;
  logic [31:0] instr, pc, o_pc, o_instr, o_imm, o_cnt;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [2:0]  o_f3;
  logic        o_f75, o_wr, o_cf;
  logic [3:0]  o_class;
  int checks = 0;
  int errors = 0;

`ifdef CPU_DECODE_RV32M_EN
  localparam logic [3:0] MUL_CLASS = 4'd11;
  localparam logic       MUL_WR    = 1'b1;
`else
  localparam logic [3:0] MUL_CLASS = 4'd15;
  localparam logic       MUL_WR    = 1'b0;
`endif

  cpu_decode #(.TAG_WIDTH(8)) dut (
    .i_clock(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush), .o_busy(busy),
    .i_tag(tag), .i_instruction(instr), .i_pc(pc), .o_tag(o_tag), .o_pc(o_pc),
    .o_instruction(o_instr), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_imm(o_imm),
    .o_funct3(o_f3), .o_funct7_5(o_f75), .o_class(o_class), .o_writes_rd(o_wr),
    .o_control_flow(o_cf), .o_decoded_count(o_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; tag = 8'd0; instr = 32'h0; pc = 32'h0;
    #12;
    chk("rst_tag", {24'h0, o_tag}, 32'd0);
    chk("rst_cnt", o_cnt, 32'd0);
    chk("rst_class", {28'h0, o_class}, 32'd0);
    chk("rst_imm", o_imm, 32'd0);
    chk("rst_wr_cf", {30'h0, o_wr, o_cf}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_tag0", {24'h0, o_tag}, 32'd0);

    // addi x1,x0,-5
    tag = 8'd1; instr = 32'hFFB00093; pc = 32'h100;
    #1 chk("pre_edge_tag", {24'h0, o_tag}, 32'd0);
    tick();
    chk("addi_tag", {24'h0, o_tag}, 32'd1);
    chk("addi_class", {28'h0, o_class}, 32'd1);
    chk("addi_rd", {27'h0, o_rd}, 32'd1);
    chk("addi_rs1", {27'h0, o_rs1}, 32'd0);
    chk("addi_imm", o_imm, 32'hFFFFFFFB);
    chk("addi_wr", {31'h0, o_wr}, 32'd1);
    chk("addi_cnt", o_cnt, 32'd1);
    chk("addi_pc", o_pc, 32'h100);

    // sw x2,8(x1) then lui x5,0x12345 back-to-back
    tag = 8'd2; instr = 32'h0020A423; pc = 32'h104;
    tick();
    chk("sw_tag", {24'h0, o_tag}, 32'd2);
    chk("sw_class", {28'h0, o_class}, 32'd3);
    chk("sw_imm", o_imm, 32'd8);
    chk("sw_rs", {22'h0, o_rs1, o_rs2}, {22'h0, 5'd1, 5'd2});
    chk("sw_wr", {31'h0, o_wr}, 32'd0);
    chk("sw_f3", {29'h0, o_f3}, 32'd2);
    tag = 8'd3; instr = 32'h123452B7; pc = 32'h108;
    tick();
    chk("lui_tag", {24'h0, o_tag}, 32'd3);
    chk("lui_class", {28'h0, o_class}, 32'd7);
    chk("lui_imm", o_imm, 32'h12345000);
    chk("lui_rd", {27'h0, o_rd}, 32'd5);
    chk("lui_instr", o_instr, 32'h123452B7);
    tick();
    chk("hold_tag", {24'h0, o_tag}, 32'd3);
    chk("hold_cnt", o_cnt, 32'd3);

    // beq x0,x0,-4
    tag = 8'd4; instr = 32'hFE000EE3; pc = 32'h10C;
    tick();
    chk("beq_tag", {24'h0, o_tag}, 32'd4);
    chk("beq_class", {28'h0, o_class}, 32'd4);
    chk("beq_imm", o_imm, 32'hFFFFFFFC);
    chk("beq_cf", {31'h0, o_cf}, 32'd1);
    chk("beq_wr", {31'h0, o_wr}, 32'd0);

    // mul x3,x1,x2 held under stall for three edges
    tag = 8'd5; instr = 32'h022081B3; pc = 32'h110; stall = 1'b1;
    #1 chk("busy_on", {31'h0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_tag", {24'h0, o_tag}, 32'd4);
      chk("stall_class", {28'h0, o_class}, 32'd4);
    end
    stall = 1'b0;
    #1 chk("busy_off", {31'h0, busy}, 32'd0);
    tick();
    chk("mul_tag", {24'h0, o_tag}, 32'd5);
    chk("mul_class", {28'h0, o_class}, {28'h0, MUL_CLASS});
    chk("mul_wr", {31'h0, o_wr}, {31'h0, MUL_WR});
    tick();
    chk("mul_once", {24'h0, o_tag}, 32'd5);
    chk("mul_cnt", o_cnt, 32'd5);

    // flush discards a pending new tag
    tag = 8'd6; instr = 32'h00000000; flush = 1'b1;
    tick();
    chk("flush_tag", {24'h0, o_tag}, 32'd5);
    flush = 1'b0;
    tick();
    chk("flush_after", {24'h0, o_tag}, 32'd5);
    chk("flush_cnt", o_cnt, 32'd5);

    // flush while stalled still discards
    tag = 8'd7; instr = 32'h008000EF; stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    tick();
    chk("flush_stall", {24'h0, o_tag}, 32'd5);

    // all-zero word is illegal
    tag = 8'd8; instr = 32'h00000000;
    tick();
    chk("zero_tag", {24'h0, o_tag}, 32'd6);
    chk("zero_class", {28'h0, o_class}, 32'd15);
    chk("zero_wr_cf", {30'h0, o_wr, o_cf}, 32'd0);

    // jal x1,8 and mret
    tag = 8'd9; instr = 32'h008000EF;
    tick();
    chk("jal_class", {28'h0, o_class}, 32'd5);
    chk("jal_imm", o_imm, 32'd8);
    chk("jal_wr_cf", {30'h0, o_wr, o_cf}, 32'd3);
    tag = 8'd10; instr = 32'h30200073;
    tick();
    chk("mret_class", {28'h0, o_class}, 32'd9);
    chk("mret_cf", {31'h0, o_cf}, 32'd1);
    chk("mret_cnt", o_cnt, 32'd8);

    // asynchronous reset during a stall
    tag = 8'd11; stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_tag", {24'h0, o_tag}, 32'd0);
    chk("arst_cnt", o_cnt, 32'd0);
    chk("arst_class", {28'h0, o_class}, 32'd0);
    rst = 1'b0; tag = 8'd0; stall = 1'b0;
    tick();
    chk("arst_idle", {24'h0, o_tag}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
